// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle of the shared immediate extender: two requester
// channels and one result channel, all valid/ready.
interface imm_ext_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_instr;
  logic [1:0]        req0_fmt;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_instr;
  logic [1:0]        req1_fmt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic              out_id;

  modport master (
    output req0_valid, req0_instr, req0_fmt,
    input  req0_ready,
    output req1_valid, req1_instr, req1_fmt,
    input  req1_ready,
    input  out_valid, out_imm, out_id,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_instr, req0_fmt,
    output req0_ready,
    input  req1_valid, req1_instr, req1_fmt,
    output req1_ready,
    output out_valid, out_imm, out_id,
    input  out_ready
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin shared 12-to-32 immediate extender for decode (port 0) and
// LSU (port 1); one registered result per grant over valid/ready.
module imm_ext_arbiter #(
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  imm_ext_arbiter_if.slave bus
);

  localparam logic [1:0] FMT_I = 2'd0;
  localparam logic [1:0] FMT_S = 2'd1;
  localparam logic [1:0] FMT_B = 2'd2;
  localparam logic [1:0] FMT_U = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // U-type keeps all 20 upper bits; the other formats use only the low 12.
  function automatic logic [19:0] extract_field(input logic [DATA_W-1:7] hi,
                                                input logic [1:0]        fmt);
    case (fmt)
      FMT_I:   return {8'h00, hi[31:20]};
      FMT_S:   return {8'h00, hi[31:25], hi[11:7]};
      FMT_B:   return {8'h00, hi[31], hi[7], hi[30:25], hi[11:8]};
      default: return hi[31:12];
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] sign_extend(input logic [19:0] fld,
                                                           input logic [1:0]  fmt);
    logic signed [11:0]       f12;
    logic signed [DATA_W-1:0] wide;
    f12  = fld[11:0];
    wide = f12;
    case (fmt)
      FMT_B:   return wide <<< 1;
      FMT_U:   return {fld, 12'h000};
      default: return wide;
    endcase
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_vld;
  logic              grant_id;
  logic [DATA_W-1:7] sel_hi;

  logic [19:0]       fld_p0;
  logic [1:0]        fmt_p0;
  logic              id_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] imm_p1;
  logic              id_p1;

  // Grants are only issued from IDLE; a tie goes to the port not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && state == IDLE && (bus.req0_valid || bus.req1_valid)) begin
      grant_vld = 1'b1;
      grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    end
  end

  assign bus.req0_ready = grant_vld && !grant_id;
  assign bus.req1_ready = grant_vld &&  grant_id;
  assign sel_hi = grant_id ? bus.req1_instr[DATA_W-1:7] : bus.req0_instr[DATA_W-1:7];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXT;
      EXT:     state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_vld) last_grant <= grant_id;
    end
  end

  // Stage p0: latch the granted request's field, format and owner
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      fld_p0 <= extract_field(sel_hi, grant_id ? bus.req1_fmt : bus.req0_fmt);
      fmt_p0 <= grant_id ? bus.req1_fmt : bus.req0_fmt;
      id_p0  <= grant_id;
    end
  end

  // Stage p1: extended result, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      id_p1  <= 1'b0;
    end else if (state == EXT) begin
      vld_p1 <= 1'b1;
      imm_p1 <= sign_extend(fld_p0, fmt_p0);
      id_p1  <= id_p0;
    end else if (state == HOLD && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_imm   = imm_p1;
  assign bus.out_id    = id_p1;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: directed scenarios plus random traffic
// checked against a rule-level model of arbitration, latency and extension.
module tb_imm_ext_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_ext_arbiter_if #(.DATA_W(32)) bus ();

  imm_ext_arbiter #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] imm;
    logic        id;
    int          due;
  } exp_t;

  exp_t q[$];

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] fmt);
    logic [11:0] f;
    case (fmt)
      2'd0: begin f = ins[31:20];                               return {{20{f[11]}}, f}; end
      2'd1: begin f = {ins[31:25], ins[11:7]};                  return {{20{f[11]}}, f}; end
      2'd2: begin f = {ins[31], ins[7], ins[30:25], ins[11:8]}; return {{19{f[11]}}, f, 1'b0}; end
      default: return {ins[31:12], 12'h000};
    endcase
  endfunction

  // Monitor / scoreboard
  int          cyc = 0;
  bit          busy = 0, mlast = 1;
  bit          prev_valid = 0, prev_hold = 0, prev_hs = 0;
  logic [31:0] pimm;
  logic        pid;

  always @(negedge clk) begin
    bit   b0, g, v0, v1, r0, r1, ov, ordy;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      busy = 0; mlast = 1;
      prev_valid = 0; prev_hold = 0; prev_hs = 0;
    end else begin
      b0 = busy;
      v0 = bus.req0_valid; v1 = bus.req1_valid;
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      ov = bus.out_valid;  ordy = bus.out_ready;
      chk(!(r0 && r1), "ready_onehot", 32'({r1, r0}), 32'h1);
      if (b0) chk(!(r0 || r1), "ready_while_busy", 32'({r1, r0}), 32'h0);
      if (prev_hold)
        chk(ov && bus.out_imm == pimm && bus.out_id == pid, "hold_stable", bus.out_imm, pimm);
      if (prev_hs) chk(!ov, "valid_one_cycle", 32'(ov), 32'h0);
      if (ov && !prev_valid) begin
        if (q.size() == 0) chk(1'b0, "unexpected_out", bus.out_imm, 32'h0);
        else chk(cyc == q[0].due, "latency", 32'(cyc), 32'(q[0].due));
      end
      if (ov && ordy && q.size() != 0) begin
        e = q.pop_front();
        chk(bus.out_imm == e.imm, "sb_imm", bus.out_imm, e.imm);
        chk(bus.out_id == e.id, "sb_id", 32'(bus.out_id), 32'(e.id));
        busy = 0;
      end else if (!ov && q.size() != 0 && cyc > q[0].due) begin
        chk(1'b0, "late_result", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
        busy = 0;
      end
      if ((r0 && v0) || (r1 && v1)) begin
        g = r1;
        if (v0 && v1) chk(g != mlast, "rr_tie", 32'(g), 32'(!mlast));
        else          chk(g == v1, "single_grant", 32'(g), 32'(v1));
        mlast = g;
        e.imm = ref_imm(g ? bus.req1_instr : bus.req0_instr, g ? bus.req1_fmt : bus.req0_fmt);
        e.id  = g;
        e.due = cyc + 2;
        q.push_back(e);
        busy = 1;
      end else begin
        chk(b0 || !(v0 || v1), "idle_grant", 32'({r1, r0}), 32'h1);
      end
      prev_valid = ov;
      prev_hold  = ov && !ordy;
      prev_hs    = ov && ordy;
      pimm = bus.out_imm;
      pid  = bus.out_id;
    end
  end

  task automatic issue(input bit p, input logic [31:0] ins, input logic [1:0] fmt);
    bit got = 0;
    @(posedge clk); #1;
    if (p) begin bus.req1_valid = 1; bus.req1_instr = ins; bus.req1_fmt = fmt; end
    else   begin bus.req0_valid = 1; bus.req0_instr = ins; bus.req0_fmt = fmt; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
    end
    chk(got, "accept_timeout", 32'(got), 32'h1);
    @(posedge clk); #1;
    if (p) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask

  task automatic expect_out(input logic [31:0] imm, input logic id, input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk(seen, {name, "_timeout"}, 32'(seen), 32'h1);
    if (seen) begin
      chk(bus.out_imm == imm, name, bus.out_imm, imm);
      chk(bus.out_id == id, {name, "_id"}, 32'(bus.out_id), 32'(id));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit a0, a1, got;
    logic [31:0] himm;
    rst_n = 0;
    bus.req0_valid = 1; bus.req0_instr = 32'h00100013; bus.req0_fmt = 2'd0;
    bus.req1_valid = 0; bus.req1_instr = '0; bus.req1_fmt = 2'd0;
    bus.out_ready = 1;
    #1;
    chk(!bus.out_valid && bus.out_imm == 32'h0 && !bus.out_id, "reset_outputs", bus.out_imm, 32'h0);
    chk(!bus.req0_ready && !bus.req1_ready, "reset_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 0;
    #2 rst_n = 1;

    // Directed formats
    issue(0, 32'hFD000013, 2'd0); expect_out(32'hFFFFFFD0, 1'b0, "i_type");
    issue(0, 32'h7E000FE3, 2'd2); expect_out(32'h00000FFE, 1'b0, "b_type");
    issue(0, 32'h12345037, 2'd3); expect_out(32'h12345000, 1'b0, "u_type");
    issue(1, 32'h020006A3, 2'd1); expect_out(32'h0000002D, 1'b1, "s_type");

    // Both requesters held valid: results alternate starting with port 0
    bus.req0_valid = 1; bus.req0_instr = 32'h00000013; bus.req0_fmt = 2'd0;
    bus.req1_valid = 1; bus.req1_instr = 32'h7FF00013; bus.req1_fmt = 2'd0;
    expect_out(32'h00000000, 1'b0, "rr_first");
    expect_out(32'h000007FF, 1'b1, "rr_second");
    expect_out(32'h00000000, 1'b0, "rr_third");
    bus.req0_valid = 0; bus.req1_valid = 0;

    // Backpressure in HOLD with a competing request pending
    bus.out_ready = 0;
    issue(0, 32'hFE000FA3, 2'd1);
    expect_out(32'hFFFFFFFF, 1'b0, "bp_result");
    himm = bus.out_imm;
    bus.req1_valid = 1; bus.req1_instr = 32'h00100013; bus.req1_fmt = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(bus.out_valid && bus.out_imm == himm && !bus.out_id, "bp_stable", bus.out_imm, himm);
      chk(!bus.req0_ready && !bus.req1_ready, "bp_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'h0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    @(negedge clk);
    chk(bus.out_valid && !bus.req1_ready, "bp_release", 32'({bus.req1_ready, bus.out_valid}), 32'h1);
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      got = bus.req1_ready;
    end
    chk(got, "bp_next_grant", 32'(got), 32'h1);
    @(posedge clk); #1;
    bus.req1_valid = 0;
    expect_out(32'h00000001, 1'b1, "bp_follow");

    // Reset while the result is in EXT
    issue(0, 32'hABCDE037, 2'd3);
    #1 rst_n = 0;
    #1;
    chk(!bus.out_valid && bus.out_imm == 32'h0, "rst_in_ext", bus.out_imm, 32'h0);
    @(negedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(!bus.out_valid, "rst_discard", 32'(bus.out_valid), 32'h0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1; bus.req0_instr = 32'h00500013; bus.req0_fmt = 2'd0;
    bus.req1_valid = 1; bus.req1_instr = 32'h00700013; bus.req1_fmt = 2'd0;
    @(negedge clk);
    chk(bus.req0_ready && !bus.req1_ready, "tie_after_reset", 32'({bus.req1_ready, bus.req0_ready}), 32'h1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    expect_out(32'h00000005, 1'b0, "post_rst0");
    expect_out(32'h00000007, 1'b1, "post_rst1");
    bus.req1_valid = 0;

    // Random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (a0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom % 3) != 0;
        bus.req0_instr = $urandom;
        bus.req0_fmt   = 2'($urandom);
      end
      if (a1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom % 3) != 0;
        bus.req1_instr = $urandom;
        bus.req1_fmt   = 2'($urandom);
      end
      bus.out_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    @(posedge clk); #1;
    if (a0 || !bus.req0_valid) bus.req0_valid = 0;
    if (a1 || !bus.req1_valid) bus.req1_valid = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (a0) bus.req0_valid = 0;
      if (a1) bus.req1_valid = 0;
    end
    repeat (6) @(negedge clk);
    chk(q.size() == 0 && !bus.req0_valid && !bus.req1_valid, "drain", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shared immediate-extension unit for the RISC-V core. It arbitrates one 12-to-32 sign-extension datapath between two requesters: port 0 (decode) and port 1 (load/store address unit). It extracts the immediate field for the requested format, sign-extends it, and returns a registered 32-bit immediate over a valid/ready handshake. Arbitration is round-robin, and the block sits between decode/LSU and the ALU operand mux.

## Interface
Parameters:
- `DATA_W`, 32, instruction and immediate width. Fixed; other values are unsupported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_ready`  out  1  request 0 accepted this cycle.
- `req0_instr`  in  32  raw instruction word from requester 0.
- `req0_fmt`  in  2  immediate format: 0 = I, 1 = S, 2 = B, 3 = U.
- `req1_valid`, `req1_ready`, `req1_instr`, `req1_fmt`: same as port 0, for requester 1.
- `out_valid`  out  1  `out_imm` and `out_id` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_imm`  out  32  extended immediate.
- `out_id`  out  1  requester that owns the result (0 or 1).

## Operation
- FSM states: IDLE, EXT, HOLD.
- IDLE, no `reqN_valid`: stay in IDLE.
- IDLE, any `reqN_valid`:
  - grant one requester;
  - assert `reqN_ready` combinationally for the granted port only;
  - latch its 12-bit field, fmt and id (U-type: latch `instr[31:12]`);
  - go to EXT.
- EXT: sign-extend the latched field, register the result into `out_imm`, set `out_valid=1`, go to HOLD.
- HOLD: hold `out_imm`, `out_id` and `out_valid` stable. When `out_ready=1`, clear `out_valid` and go to IDLE.
- Field extraction (12 bits):
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8]}`.
- Extension rules:
  - I and S: `out_imm = {{20{f[11]}}, f}`.
  - B: `out_imm = {{19{f[11]}}, f, 1'b0}`. The field is the 12-bit extender input, shifted left by one.
  - U: `out_imm = {instr[31:12], 12'h000}`. This bypasses the extender.
- Arbitration:
  - Only one valid request: grant it.
  - Both valid: grant the port that is not `last_grant`.
  - `last_grant` updates on every grant.
  - Reset value of `last_grant` is 1, so port 0 wins the first tie.
- A requester not granted sees `ready=0` and must hold its `valid`, `instr` and `fmt` stable until granted.
- `reqN_ready` is never asserted in EXT or HOLD.
- Requests that arrive or change during EXT or HOLD are ignored until IDLE.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - state = IDLE, `out_valid=0`, `out_imm=32'h0`, `out_id=0`, `last_grant=1`;
  - `req0_ready=0`, `req1_ready=0`.
- Reset mid-operation, in any state: the result in flight is discarded and the outputs take their reset values immediately. After `rst_n` deasserts, the first grant occurs on the first rising edge with a valid request.
- Latency:
  - request accepted in cycle T (valid and ready high at the edge);
  - `out_valid=1` from cycle T+2;
  - with `out_ready` held high, `out_valid` is high for exactly one cycle.
- Throughput: one result per 3 cycles with no backpressure.
- Backpressure: with `out_ready=0`, HOLD persists indefinitely and the outputs stay stable.
- The HOLD→IDLE transition and a new grant never occur in the same cycle. The next grant is at the earliest one cycle after the handshake.
- `out_imm` keeps its last value after `out_valid` falls. It is a don't-care to consumers.

## Test plan
- Reset, then `req0` I-type, `instr=32'hFD000013` → `out_imm=32'hFFFFFFD0`, `out_id=0`, at T+2.
- `req1` S-type, `instr=32'h020006A3` (immediate 45) → `out_imm=32'h0000002D`, `out_id=1`.
- `req0` B-type, `instr=32'h7E000FE3` (field `12'h7FF`) → `out_imm=32'h00000FFE`. Then U-type, `instr=32'h12345037` → `out_imm=32'h12345000`.
- Both valid continuously, with immediates 0 (port 0) and 2047 I-type (port 1) → alternating results `0x00000000` (id 0), `0x000007FF` (id 1), then id 0 again. Each ready pulse is on exactly one port.
- Backpressure: `out_ready=0` for 10 cycles in HOLD → `out_valid`, `out_imm` and `out_id` stay constant, and no `reqN_ready` is asserted. After `out_ready=1`: one handshake, then return to IDLE.
- `rst_n` pulsed low while in EXT → `out_valid=0` and `out_imm=0` immediately. The pending result never appears, and the next tie after reset goes to port 0.
